// File: rtl/iomem_pkg.sv
// Shared types and sizes for the iomem initiator.
//   BLOCK_SIZE : bits moved per iomem transfer
//   NUMS_BYTE  : byte lanes per transfer (one strobe bit each)
//   ADDR_W     : iomem address width
//   state_e    : initiator FSM states
//   owner_e    : which cache owns the transaction in flight
//   iomem_req_t: the registered copy of the accepted request
package iomem_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int NUMS_BYTE  = BLOCK_SIZE / 8;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [NUMS_BYTE-1:0]  wstrb;
    logic [BLOCK_SIZE-1:0] wdata;
  } iomem_req_t;

endpackage

// File: rtl/iomem_rr_arb.sv
// Two-input round-robin arbiter.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   req   : request vector, bit 0 = instruction fetch, bit 1 = data
//   en    : arbitration allowed this cycle (grant is forced to 0 otherwise)
//   grant : one-hot grant, combinational from req/en and the last-grant flop
module iomem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // Remembers who won last; 0 = fetch side, so the data side wins the first tie.
  logic last_dc;

  // A lone requester always wins; on a tie the side that did not win last time goes.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_dc ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Only an actual grant moves the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dc <= 1'b0;
    end else if (|grant) begin
      last_dc <= grant[1];
    end
  end

endmodule

// File: rtl/iomem_initiator.sv
// Bus initiator for the 128-bit iomem valid/ready port. Arbitrates the fetch
// (ic) and data (dc) block requests, runs one transaction at a time, keeps it
// stable until the responder answers, and returns data/acks to the owner.
// A transaction left unanswered for TIMEOUT cycles is closed with an error.
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-high reset
//   ic_req_valid_i/ready_o, ic_addr_i: fetch request (read only)
//   ic_rsp_valid_o/err_o, ic_rdata_o : fetch response pulse, error flag, data
//   dc_req_valid_i/ready_o, dc_addr_i,
//   dc_wstrb_i, dc_wdata_i           : data request, all-zero strobes = read
//   dc_rsp_valid_o/err_o, dc_rdata_o : data response pulse, error flag, data
//   iomem_valid_o/ready_i            : memory-side handshake
//   iomem_wstrb_o/addr_o/wdata_o     : in-flight transaction fields
//   iomem_rdata_i                    : memory read data, valid with ready
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ic_req_valid_i,
  output logic                  ic_req_ready_o,
  input  logic [ADDR_W-1:0]     ic_addr_i,
  output logic                  ic_rsp_valid_o,
  output logic                  ic_rsp_err_o,
  output logic [BLOCK_SIZE-1:0] ic_rdata_o,
  input  logic                  dc_req_valid_i,
  output logic                  dc_req_ready_o,
  input  logic [ADDR_W-1:0]     dc_addr_i,
  input  logic [NUMS_BYTE-1:0]  dc_wstrb_i,
  input  logic [BLOCK_SIZE-1:0] dc_wdata_i,
  output logic                  dc_rsp_valid_o,
  output logic                  dc_rsp_err_o,
  output logic [BLOCK_SIZE-1:0] dc_rdata_o,
  output logic                  iomem_valid_o,
  input  logic                  iomem_ready_i,
  output logic [NUMS_BYTE-1:0]  iomem_wstrb_o,
  output logic [ADDR_W-1:0]     iomem_addr_o,
  output logic [BLOCK_SIZE-1:0] iomem_wdata_o,
  input  logic [BLOCK_SIZE-1:0] iomem_rdata_i
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it is never compared.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  owner_e           owner;
  iomem_req_t       req_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       grant;
  logic             tmo_hit;
  logic             done;
  logic [BLOCK_SIZE-1:0] rsp_data;
  iomem_req_t       ic_req;
  iomem_req_t       dc_req;

  // New grants are only handed out from IDLE, which also guarantees the
  // idle gap on iomem_valid_o after every RESP cycle.
  iomem_rr_arb u_arb (
    .clk   (clk_i),
    .rst   (rst_ni),
    .req   ({dc_req_valid_i, ic_req_valid_i}),
    .en    (state == IDLE),
    .grant (grant)
  );

  assign ic_req_ready_o = grant[0];
  assign dc_req_ready_o = grant[1];

  assign ic_req = '{addr: ic_addr_i, wstrb: '0, wdata: '0};
  assign dc_req = '{addr: dc_addr_i, wstrb: dc_wstrb_i, wdata: dc_wdata_i};

  // The counter value here equals the number of earlier BUSY cycles, so
  // TMO_LAST means this is the TIMEOUT-th cycle without an answer. A ready
  // in that same cycle still completes normally.
  assign tmo_hit  = (TIMEOUT != 0) && !iomem_ready_i && (tmo_cnt == TMO_LAST);
  assign done     = iomem_ready_i || tmo_hit;
  assign rsp_data = (iomem_ready_i && (req_q.wstrb == '0)) ? iomem_rdata_i : '0;

  assign iomem_addr_o  = req_q.addr;
  assign iomem_wstrb_o = req_q.wstrb;
  assign iomem_wdata_o = req_q.wdata;

  // Main FSM. Everything the outside world sees is registered here, so the
  // response pulse appears exactly in the RESP cycle and a reset clears all
  // of it at once without issuing any response.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state          <= IDLE;
      owner          <= IC;
      req_q          <= '0;
      tmo_cnt        <= '0;
      iomem_valid_o  <= 1'b0;
      ic_rsp_valid_o <= 1'b0;
      ic_rsp_err_o   <= 1'b0;
      ic_rdata_o     <= '0;
      dc_rsp_valid_o <= 1'b0;
      dc_rsp_err_o   <= 1'b0;
      dc_rdata_o     <= '0;
    end else begin
      ic_rsp_valid_o <= 1'b0;
      ic_rsp_err_o   <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      dc_rsp_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            state         <= BUSY;
            owner         <= grant[1] ? DC : IC;
            req_q         <= grant[1] ? dc_req : ic_req;
            tmo_cnt       <= '0;
            iomem_valid_o <= 1'b1;
          end
        end
        BUSY: begin
          if (done) begin
            state         <= RESP;
            iomem_valid_o <= 1'b0;
            if (owner == DC) begin
              dc_rsp_valid_o <= 1'b1;
              dc_rsp_err_o   <= !iomem_ready_i;
              dc_rdata_o     <= rsp_data;
            end else begin
              ic_rsp_valid_o <= 1'b1;
              ic_rsp_err_o   <= !iomem_ready_i;
              ic_rdata_o     <= rsp_data;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed testbench for iomem_initiator. Two instances share the request
// inputs: dutA uses the default timeout, dutB uses TIMEOUT=8. Each has its
// own iomem ready input so the responder of one can be stalled independently.
module tb_iomem_initiator;
  import iomem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  icReqValid = 1'b0;
  logic [ADDR_W-1:0]     icAddr = '0;
  logic                  dcReqValid = 1'b0;
  logic [ADDR_W-1:0]     dcAddr = '0;
  logic [NUMS_BYTE-1:0]  dcWstrb = '0;
  logic [BLOCK_SIZE-1:0] dcWdata = '0;
  logic [BLOCK_SIZE-1:0] memRdata = '0;
  logic                  readyA = 1'b0;
  logic                  readyB = 1'b0;

  logic icReqReadyA, icRspValidA, icRspErrA, dcReqReadyA, dcRspValidA, dcRspErrA, validA;
  logic [BLOCK_SIZE-1:0] icRdataA, dcRdataA, wdataA;
  logic [NUMS_BYTE-1:0]  wstrbA;
  logic [ADDR_W-1:0]     addrA;

  logic icReqReadyB, icRspValidB, icRspErrB, dcReqReadyB, dcRspValidB, dcRspErrB, validB;
  logic [BLOCK_SIZE-1:0] icRdataB, dcRdataB, wdataB;
  logic [NUMS_BYTE-1:0]  wstrbB;
  logic [ADDR_W-1:0]     addrB;

  iomem_initiator dutA (
    .clk_i(clk), .rst_ni(rst),
    .ic_req_valid_i(icReqValid), .ic_req_ready_o(icReqReadyA), .ic_addr_i(icAddr),
    .ic_rsp_valid_o(icRspValidA), .ic_rsp_err_o(icRspErrA), .ic_rdata_o(icRdataA),
    .dc_req_valid_i(dcReqValid), .dc_req_ready_o(dcReqReadyA), .dc_addr_i(dcAddr),
    .dc_wstrb_i(dcWstrb), .dc_wdata_i(dcWdata),
    .dc_rsp_valid_o(dcRspValidA), .dc_rsp_err_o(dcRspErrA), .dc_rdata_o(dcRdataA),
    .iomem_valid_o(validA), .iomem_ready_i(readyA), .iomem_wstrb_o(wstrbA),
    .iomem_addr_o(addrA), .iomem_wdata_o(wdataA), .iomem_rdata_i(memRdata)
  );

  iomem_initiator #(.TIMEOUT(8)) dutB (
    .clk_i(clk), .rst_ni(rst),
    .ic_req_valid_i(icReqValid), .ic_req_ready_o(icReqReadyB), .ic_addr_i(icAddr),
    .ic_rsp_valid_o(icRspValidB), .ic_rsp_err_o(icRspErrB), .ic_rdata_o(icRdataB),
    .dc_req_valid_i(dcReqValid), .dc_req_ready_o(dcReqReadyB), .dc_addr_i(dcAddr),
    .dc_wstrb_i(dcWstrb), .dc_wdata_i(dcWdata),
    .dc_rsp_valid_o(dcRspValidB), .dc_rsp_err_o(dcRspErrB), .dc_rdata_o(dcRdataB),
    .iomem_valid_o(validB), .iomem_ready_i(readyB), .iomem_wstrb_o(wstrbB),
    .iomem_addr_o(addrB), .iomem_wdata_o(wdataB), .iomem_rdata_i(memRdata)
  );

  int passCount = 0;
  int checkCount = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Holds reset across two rising edges and releases it mid-low-phase.
  task automatic doReset();
    rst = 1'b1;
    icReqValid = 1'b0;
    dcReqValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request and waits (bounded) for the chosen instance to take
  // it. Returns 1ns after the accepting edge with the request withdrawn.
  task automatic applyStimulus(input bit selB, input bit useDc, input logic [31:0] addr,
                               input logic [15:0] wstrb, input logic [127:0] wdata, output bit accepted);
    logic rdy;
    @(negedge clk);
    if (useDc) begin
      dcReqValid = 1'b1; dcAddr = addr; dcWstrb = wstrb; dcWdata = wdata;
    end else begin
      icReqValid = 1'b1; icAddr = addr;
    end
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy = selB ? (useDc ? dcReqReadyB : icReqReadyB) : (useDc ? dcReqReadyA : icReqReadyA);
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end
    icReqValid = 1'b0;
    dcReqValid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int validCnt, addrBad, rspCnt, otherRsp, rspCyc, nGrant;
    logic [127:0] gotData;
    logic gotErr;
    int grantDc[4];
    int grantCyc[4];
    logic [127:0] patA5, patB, patIc, patArb;
    patA5  = {16{8'hA5}};
    patB   = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    patIc  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    patArb = {16{8'h77}};

    doReset();

    // Reset state
    #1;
    checkOutput("rst_valid", validA, 0);
    checkOutput("rst_fields", {addrA, wstrbA, wdataA}, 0);
    checkOutput("rst_rsp", {icRspValidA, icRspErrA, dcRspValidA, dcRspErrA}, 0);
    checkOutput("rst_rdata", icRdataA | dcRdataA, 0);
    checkOutput("rst_ready", {icReqReadyA, dcReqReadyA}, 0);

    // DC read, responder answers in the 17th valid cycle
    memRdata = patA5;
    applyStimulus(0, 1, 32'h4000_0010, 16'h0000, '0, acc);
    checkOutput("t1_accept", acc, 1);
    validCnt = 0; addrBad = 0; rspCnt = 0; otherRsp = 0; gotData = '0; gotErr = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (validA) begin
        validCnt++;
        if (addrA !== 32'h4000_0010) addrBad++;
      end
      if (dcRspValidA) begin rspCnt++; gotData = dcRdataA; gotErr = dcRspErrA; end
      if (icRspValidA) otherRsp++;
      readyA = (k == 17);
    end
    checkOutput("t1_valid_cycles", validCnt, 17);
    checkOutput("t1_addr_stable", addrBad, 0);
    checkOutput("t1_rsp_count", rspCnt, 1);
    checkOutput("t1_rdata", gotData, patA5);
    checkOutput("t1_err", gotErr, 0);
    checkOutput("t1_no_ic_rsp", otherRsp, 0);
    checkOutput("t1_rdata_held", dcRdataA, patA5);

    // IC read with same-cycle ready
    readyA = 1'b1;
    memRdata = patIc;
    applyStimulus(0, 0, 32'h3000_0004, 16'h0000, '0, acc);
    checkOutput("t2_accept", acc, 1);
    @(negedge clk);
    checkOutput("t2_valid_n1", validA, 1);
    checkOutput("t2_addr", addrA, 32'h3000_0004);
    checkOutput("t2_no_rsp_n1", icRspValidA, 0);
    @(negedge clk);
    checkOutput("t2_valid_n2", validA, 0);
    checkOutput("t2_rsp_n2", icRspValidA, 1);
    checkOutput("t2_rdata", icRdataA, patIc);
    @(negedge clk);
    checkOutput("t2_valid_n3", validA, 0);
    checkOutput("t2_rsp_pulse", icRspValidA, 0);
    checkOutput("t2_rdata_held", icRdataA, patIc);

    // DC write: strobes/data forwarded, ack carries zero data
    memRdata = {128{1'b1}};
    applyStimulus(0, 1, 32'h4000_0100, 16'h00F0, patB, acc);
    checkOutput("t3_accept", acc, 1);
    @(negedge clk);
    checkOutput("t3_wstrb", wstrbA, 16'h00F0);
    checkOutput("t3_wdata", wdataA, patB);
    checkOutput("t3_addr", addrA, 32'h4000_0100);
    @(negedge clk);
    checkOutput("t3_rsp", dcRspValidA, 1);
    checkOutput("t3_rdata_zero", dcRdataA, 0);
    checkOutput("t3_err", dcRspErrA, 0);

    // Both request together from reset: DC, IC, DC, IC, three cycles apart
    doReset();
    readyA = 1'b1; readyB = 1'b1;
    memRdata = patArb;
    @(negedge clk);
    icReqValid = 1'b1; icAddr = 32'h3000_0040;
    dcReqValid = 1'b1; dcAddr = 32'h4000_0040; dcWstrb = '0;
    nGrant = 0;
    for (int c = 0; c < 40 && nGrant < 4; c++) begin
      #1;
      if (icReqReadyA || dcReqReadyA) begin
        grantDc[nGrant] = (dcReqReadyA && !icReqReadyA) ? 1 : (icReqReadyA && !dcReqReadyA) ? 0 : 2;
        grantCyc[nGrant] = c;
        nGrant++;
      end
      @(negedge clk);
    end
    icReqValid = 1'b0;
    dcReqValid = 1'b0;
    checkOutput("arb_count", nGrant, 4);
    checkOutput("arb_first_dc", grantDc[0], 1);
    checkOutput("arb_second_ic", grantDc[1], 0);
    checkOutput("arb_third_dc", grantDc[2], 1);
    checkOutput("arb_fourth_ic", grantDc[3], 0);
    checkOutput("arb_spacing", grantCyc[1] - grantCyc[0], 3);
    repeat (4) @(negedge clk);

    // Reset asserted while BUSY
    readyA = 1'b0;
    applyStimulus(0, 1, 32'h4000_0200, 16'h0000, '0, acc);
    checkOutput("t5_accept", acc, 1);
    repeat (3) @(negedge clk);
    checkOutput("t5_busy_valid", validA, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_drop", validA, 0);
    checkOutput("t5_rdata_cleared", dcRdataA, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rspCnt = 0; validCnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dcRspValidA || icRspValidA) rspCnt++;
      if (validA) validCnt++;
    end
    checkOutput("t5_no_rsp", rspCnt, 0);
    checkOutput("t5_idle_valid", validCnt, 0);
    readyA = 1'b1;
    memRdata = patB;
    applyStimulus(0, 1, 32'h4000_0210, 16'h0000, '0, acc);
    checkOutput("t5_reaccept", acc, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_rsp_after", dcRspValidA, 1);
    checkOutput("t5_rdata_after", dcRdataA, patB);

    // Timeout on dutB (TIMEOUT=8); dutA gets stuck busy and is ignored
    doReset();
    readyA = 1'b0; readyB = 1'b1;
    memRdata = patB;
    applyStimulus(1, 1, 32'h4000_0020, 16'h0000, '0, acc);
    checkOutput("t6_pre_accept", acc, 1);
    @(negedge clk);
    checkOutput("t6_pre_fields", {addrB, wstrbB, wdataB}, {32'h4000_0020, 16'h0000, 128'h0});
    @(negedge clk);
    checkOutput("t6_pre_rsp", dcRspValidB, 1);
    checkOutput("t6_pre_rdata", dcRdataB, patB);
    readyB = 1'b0;
    applyStimulus(1, 1, 32'h4000_0030, 16'h0000, '0, acc);
    checkOutput("t6_accept", acc, 1);
    validCnt = 0; rspCnt = 0; rspCyc = 0; gotErr = 1'b0; gotData = {128{1'b1}};
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (validB) validCnt++;
      if (dcRspValidB) begin rspCnt++; rspCyc = k; gotErr = dcRspErrB; gotData = dcRdataB; end
    end
    checkOutput("t6_valid_cycles", validCnt, 8);
    checkOutput("t6_rsp_count", rspCnt, 1);
    checkOutput("t6_rsp_cycle", rspCyc, 9);
    checkOutput("t6_err", gotErr, 1);
    checkOutput("t6_rdata_zero", gotData, 0);
    readyB = 1'b1;
    memRdata = patIc;
    applyStimulus(1, 0, 32'h3000_0008, 16'h0000, '0, acc);
    checkOutput("t6_next_accept", acc, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_next_rsp", icRspValidB, 1);
    checkOutput("t6_next_err", icRspErrB, 0);
    checkOutput("t6_next_rdata", icRdataB, patIc);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
